fp_operand_aligner: RTL and testbench
=====================================

// Module: fp_operand_aligner
// PURPOSE
//  Front-end of the FP add pipeline. Unpacks two IEEE-754 single operands and compares
//  exponents. Puts the larger-exponent operand on A. Right-shifts B's mantissa to the common
//  exponent and tags the pair for the same-sign or different-sign adder. Its A/B/EXPONENT
//  outputs drive the different-sign adder inputs directly; 3-stage pipeline, valid-tagged.
// PARAMETERS
//  EXP_W   8   exponent field width (only 8 supported)
//  FRAC_W  23  stored fraction width; internal mantissa is FRAC_W+1 with hidden bit
// PORTS
//  clk          in   1   single clock, rising edge
//  rst_n        in   1   asynchronous active-low reset
//  in_valid     in   1   OP_A/OP_B valid this cycle
//  OP_A         in   32  operand a {sign,exp[7:0],frac[22:0]}
//  OP_B         in   32  operand b
//  stall        in   1   1 = hold all pipeline registers (no capture, no advance)
//  out_valid    out  1   outputs below valid
//  SIGN_A       out  1   sign of larger-exponent operand
//  MANTISSA_A   out  24  {hidden,frac} of larger-exponent operand, unshifted
//  SIGN_B       out  1   sign of smaller-exponent operand
//  MANTISSA_B   out  24  aligned (right-shifted, truncated) mantissa of smaller operand
//  EXPONENT     out  8   common exponent = larger effective exponent
//  sticky       out  1   OR of all bits shifted out of MANTISSA_B
//  diff_sign    out  1   SIGN_A != SIGN_B; 1 = route to different-sign adder
//  cancel       out  1   diff_sign & equal exp & equal mantissa (exact zero result)
//  special      out  1   either operand exp == 8'hFF (Inf/NaN); data fields don't-care
// BEHAVIOUR
//  - Reset: every output and every internal pipeline register clears to 0 immediately on
//    rst_n low, regardless of clk. First capture is on the first rising clk after rst_n
//    rises. Reset mid-stream discards all in-flight operands; no partial outputs appear.
//  - Latency: exactly 3 un-stalled clocks. If in_valid is captured at edge n, out_valid
//    and the data are valid after edge n+3. Throughput is one operand pair per clock.
//  - stall=1 holds all stages and outputs, so out_valid/data stay stable. Input is ignored
//    on stalled edges; the producer must hold OP_A/OP_B/in_valid while stall=1.
//  - Bubbles: a stage holding in_valid=0 propagates out_valid=0.
//    Data fields of invalid beats are don't-care; flags are 0.
//  - S1 (unpack): exp==0 gives hidden bit 0 and effective exponent 1 (denormal).
//    Otherwise hidden bit 1 and effective exponent = exp.
//    Compute d = eA-eB as a 9-bit signed value; record swap = (d<0).
//  - S2 (swap+shift): if swap, exchange operands.
//    On equal exponents keep input order (A=OP_A). Shift amount s = |d|.
//    For s>=24: MANTISSA_B=0 and sticky = OR of the full B mantissa.
//    s=0: no shift, sticky=0.
//  - S3 (classify/register): EXPONENT = larger effective exponent.
//    If both operands are denormal, EXPONENT=1 (not 0).
//    diff_sign=SIGN_A^SIGN_B. cancel requires s==0 and equal 24-bit mantissas.
//    special=1 if either raw exp is 8'hFF. Mantissa ordering within equal exponents is
//    NOT resolved here; the downstream adder does that.
//  - Zero operands are treated as denormals with mantissa 0; no extra flag.
//    +0 + -0 gives cancel=1.
//  - No rounding. Truncated bits are reported only through sticky.
// TESTING
//  1. reset: rst_n=0 async mid-cycle with 3 beats in flight -> all outputs 0 at once;
//     out_valid stays 0 for 3 clks after release.
//  2. A=3F800000 (1.0), B=BF000000 (-0.5) -> SIGN_A=0, MANTISSA_A=800000,
//     SIGN_B=1, MANTISSA_B=400000, EXPONENT=7F, diff_sign=1, sticky=0, at n+3.
//  3. swap: A=3F800000, B=41200000 (10.0) -> A-side=41200000 fields (mant A00000, exp 82);
//     MANTISSA_B=100000; sticky=0.
//  4. far shift: A=4B800000, B=3F800001 (d=24) -> MANTISSA_B=000000, sticky=1.
//     A=3F800000, B=BF800000 -> cancel=1.
//  5. stream 8 back-to-back pairs with stall pulsed 2 clks at beat 3 -> outputs in order,
//     none lost or duplicated; outputs frozen during stall.
//  6. denormal/special: B=00000001 vs A=00800000 -> EXPONENT=01, MANTISSA_B=000001.
//     A=7F800000 -> special=1.

Source files
------------

// File: rtl/fp_operand_aligner.sv
// Front end of the FP adder: unpacks two single-precision operands and puts the larger exponent on A.
// It right-aligns B to A and tags the pair for the same-sign or different-sign adder.
module fp_operand_aligner #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [EXP_W+FRAC_W:0]   OP_A,
    input  logic [EXP_W+FRAC_W:0]   OP_B,
    input  logic                    stall,
    output logic                    out_valid,
    output logic                    SIGN_A,
    output logic [FRAC_W:0]         MANTISSA_A,
    output logic                    SIGN_B,
    output logic [FRAC_W:0]         MANTISSA_B,
    output logic [EXP_W-1:0]        EXPONENT,
    output logic                    sticky,
    output logic                    diff_sign,
    output logic                    cancel,
    output logic                    special
);
    localparam int MW = FRAC_W + 1;
    localparam int W  = EXP_W + FRAC_W + 1;

    // input capture
    logic           v0;
    logic [W-1:0]   a0, b0;

    // S1 unpack
    logic [EXP_W-1:0]   ea_raw, eb_raw, ea_eff, eb_eff, dist_c;
    logic               a_den, b_den, swap_c;
    logic               v1, sa1, sb1, swap1, spec1;
    logic [MW-1:0]      ma1, mb1;
    logic [EXP_W-1:0]   ea1, eb1, dist1;

    assign ea_raw = a0[W-2 -: EXP_W];
    assign eb_raw = b0[W-2 -: EXP_W];
    assign a_den  = (ea_raw == '0);
    assign b_den  = (eb_raw == '0);
    assign ea_eff = a_den ? EXP_W'(1) : ea_raw;
    assign eb_eff = b_den ? EXP_W'(1) : eb_raw;
    // swap exactly when eA-eB is negative; equal exponents keep input order
    assign swap_c = (eb_eff > ea_eff);
    assign dist_c = swap_c ? (eb_eff - ea_eff) : (ea_eff - eb_eff);

    // S2 swap and shift
    logic               sa_sel, sb_sel;
    logic [MW-1:0]      ma_sel, mb_sel, mb_sh;
    logic [EXP_W-1:0]   e_sel;
    logic [2*MW-1:0]    wide;
    logic               sticky_c;
    logic               v2, sa2, sb2, zd2, st2, spec2;
    logic [MW-1:0]      ma2, mb2;
    logic [EXP_W-1:0]   e2;

    assign sa_sel = swap1 ? sb1 : sa1;
    assign sb_sel = swap1 ? sa1 : sb1;
    assign ma_sel = swap1 ? mb1 : ma1;
    assign mb_sel = swap1 ? ma1 : mb1;
    assign e_sel  = swap1 ? eb1 : ea1;
    assign wide   = {mb_sel, {MW{1'b0}}} >> dist1;

    always_comb begin
        mb_sh    = wide[2*MW-1:MW];
        sticky_c = |wide[MW-1:0];
        if (dist1 >= EXP_W'(MW)) begin
            mb_sh    = '0;
            sticky_c = |mb_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0 <= 1'b0; a0 <= '0; b0 <= '0;
            v1 <= 1'b0; sa1 <= 1'b0; sb1 <= 1'b0; swap1 <= 1'b0; spec1 <= 1'b0;
            ma1 <= '0; mb1 <= '0; ea1 <= '0; eb1 <= '0; dist1 <= '0;
            v2 <= 1'b0; sa2 <= 1'b0; sb2 <= 1'b0; zd2 <= 1'b0; st2 <= 1'b0; spec2 <= 1'b0;
            ma2 <= '0; mb2 <= '0; e2 <= '0;
            out_valid <= 1'b0; SIGN_A <= 1'b0; MANTISSA_A <= '0; SIGN_B <= 1'b0;
            MANTISSA_B <= '0; EXPONENT <= '0; sticky <= 1'b0; diff_sign <= 1'b0;
            cancel <= 1'b0; special <= 1'b0;
        end else if (!stall) begin
            v0 <= in_valid;
            a0 <= OP_A;
            b0 <= OP_B;

            v1    <= v0;
            sa1   <= a0[W-1];
            sb1   <= b0[W-1];
            ma1   <= {~a_den, a0[FRAC_W-1:0]};
            mb1   <= {~b_den, b0[FRAC_W-1:0]};
            ea1   <= ea_eff;
            eb1   <= eb_eff;
            swap1 <= swap_c;
            dist1 <= dist_c;
            spec1 <= (ea_raw == '1) || (eb_raw == '1);

            v2    <= v1;
            sa2   <= sa_sel;
            sb2   <= sb_sel;
            ma2   <= ma_sel;
            mb2   <= mb_sh;
            e2    <= e_sel;
            zd2   <= (dist1 == '0);
            st2   <= sticky_c;
            spec2 <= spec1;

            // flags are forced low on bubbles; data fields pass through
            out_valid  <= v2;
            SIGN_A     <= sa2;
            MANTISSA_A <= ma2;
            SIGN_B     <= sb2;
            MANTISSA_B <= mb2;
            EXPONENT   <= e2;
            sticky     <= v2 & st2;
            diff_sign  <= v2 & (sa2 ^ sb2);
            cancel     <= v2 & (sa2 ^ sb2) & zd2 & (ma2 == mb2);
            special    <= v2 & spec2;
        end
    end
endmodule

// File: tb/tb_fp_operand_aligner.sv
// Directed vectors for the operand aligner; a monitor pops hand-computed expectations
// from a scoreboard queue whenever the pipeline advances with out_valid high.
module tb_fp_operand_aligner;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, stall;
    logic [31:0] OP_A, OP_B;
    logic        out_valid, SIGN_A, SIGN_B, sticky, diff_sign, cancel, special;
    logic [23:0] MANTISSA_A, MANTISSA_B;
    logic [7:0]  EXPONENT;

    fp_operand_aligner #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .OP_A(OP_A), .OP_B(OP_B),
        .stall(stall), .out_valid(out_valid), .SIGN_A(SIGN_A), .MANTISSA_A(MANTISSA_A),
        .SIGN_B(SIGN_B), .MANTISSA_B(MANTISSA_B), .EXPONENT(EXPONENT), .sticky(sticky),
        .diff_sign(diff_sign), .cancel(cancel), .special(special)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sa;
        logic [23:0] ma;
        logic        sb;
        logic [23:0] mb;
        logic [7:0]  e;
        logic        st, df, cn, sp;
        logic        chk_data;
        int          tag;
    } exp_t;

    localparam int NV = 11;
    logic [31:0] va [NV];
    logic [31:0] vb [NV];
    exp_t        vexp [NV];
    exp_t        sb_q [$];
    exp_t        mon_cur, last_exp;
    logic        last_ov = 1'b0;
    int          adv_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic exp_t mk(input logic sa, input logic [23:0] ma, input logic sb,
                                input logic [23:0] mb, input logic [7:0] e, input logic st,
                                input logic df, input logic cn, input logic sp, input logic cd);
        exp_t x;
        x.sa = sa; x.ma = ma; x.sb = sb; x.mb = mb; x.e = e;
        x.st = st; x.df = df; x.cn = cn; x.sp = sp; x.chk_data = cd; x.tag = 0;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic cmp_item(input string pfx, input exp_t x);
        chk({pfx, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({pfx, "_special"}, 32'(special), 32'(x.sp));
        if (x.chk_data) begin
            chk({pfx, "_SIGN_A"}, 32'(SIGN_A), 32'(x.sa));
            chk({pfx, "_MANTISSA_A"}, 32'(MANTISSA_A), 32'(x.ma));
            chk({pfx, "_SIGN_B"}, 32'(SIGN_B), 32'(x.sb));
            chk({pfx, "_MANTISSA_B"}, 32'(MANTISSA_B), 32'(x.mb));
            chk({pfx, "_EXPONENT"}, 32'(EXPONENT), 32'(x.e));
            chk({pfx, "_sticky"}, 32'(sticky), 32'(x.st));
            chk({pfx, "_diff_sign"}, 32'(diff_sign), 32'(x.df));
            chk({pfx, "_cancel"}, 32'(cancel), 32'(x.cn));
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({pfx, "_data"}, {7'd0, SIGN_A, MANTISSA_A}, 32'd0);
        chk({pfx, "_data_b"}, {7'd0, SIGN_B, MANTISSA_B}, 32'd0);
        chk({pfx, "_exp_flags"}, {20'd0, EXPONENT, sticky, diff_sign, cancel, special}, 32'd0);
    endtask

    task automatic drive(input int idx, input logic v, input logic st);
        OP_A     = va[idx];
        OP_B     = vb[idx];
        in_valid = v;
        stall    = st;
        if (v && !st && rst_n) begin
            exp_t x;
            x = vexp[idx];
            x.tag = adv_cnt + 4;
            sb_q.push_back(x);
        end
        @(negedge clk);
    endtask

    // Monitor: pops on every advancing edge that presents out_valid; holds outputs on stalls.
    always begin
        logic adv;
        @(posedge clk);
        adv = rst_n && !stall;
        if (adv) adv_cnt++;
        #1;
        if (adv && rst_n) begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'd0);
                    last_ov = 1'b0;
                end else begin
                    mon_cur = sb_q.pop_front();
                    chk("latency_edge", adv_cnt, mon_cur.tag);
                    cmp_item("beat", mon_cur);
                    last_exp = mon_cur;
                    last_ov  = 1'b1;
                end
            end else begin
                last_ov = 1'b0;
                if (sb_q.size() > 0 && sb_q[0].tag <= adv_cnt) begin
                    chk("missing_out_valid", 32'(out_valid), 32'd1);
                    void'(sb_q.pop_front());
                end
            end
        end else if (rst_n) begin
            chk("stall_hold_valid", 32'(out_valid), 32'(last_ov));
            if (last_ov) cmp_item("stall_hold", last_exp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        va[0] = 32'h3F800000; vb[0] = 32'hBF000000;
        vexp[0] = mk(0, 24'h800000, 1, 24'h400000, 8'h7F, 0, 1, 0, 0, 1);
        va[1] = 32'h3F800000; vb[1] = 32'h41200000;
        vexp[1] = mk(0, 24'hA00000, 0, 24'h100000, 8'h82, 0, 0, 0, 0, 1);
        va[2] = 32'h4B800000; vb[2] = 32'h3F800001;
        vexp[2] = mk(0, 24'h800000, 0, 24'h000000, 8'h97, 1, 0, 0, 0, 1);
        va[3] = 32'h3F800000; vb[3] = 32'hBF800000;
        vexp[3] = mk(0, 24'h800000, 1, 24'h800000, 8'h7F, 0, 1, 1, 0, 1);
        va[4] = 32'h00800000; vb[4] = 32'h00000001;
        vexp[4] = mk(0, 24'h800000, 0, 24'h000001, 8'h01, 0, 0, 0, 0, 1);
        va[5] = 32'h7F800000; vb[5] = 32'h3F800000;
        vexp[5] = mk(0, 24'h0, 0, 24'h0, 8'h0, 0, 0, 0, 1, 0);
        va[6] = 32'h00000000; vb[6] = 32'h80000000;
        vexp[6] = mk(0, 24'h000000, 1, 24'h000000, 8'h01, 0, 1, 1, 0, 1);
        va[7] = 32'h3F800000; vb[7] = 32'h3E800001;
        vexp[7] = mk(0, 24'h800000, 0, 24'h200000, 8'h7F, 1, 0, 0, 0, 1);
        va[8] = 32'h3F800000; vb[8] = 32'hBFC00000;
        vexp[8] = mk(0, 24'h800000, 1, 24'hC00000, 8'h7F, 0, 1, 0, 0, 1);
        va[9] = 32'hC1200000; vb[9] = 32'h3F800000;
        vexp[9] = mk(1, 24'hA00000, 0, 24'h100000, 8'h82, 0, 1, 0, 0, 1);
        va[10] = 32'h4B000000; vb[10] = 32'h3F800001;
        vexp[10] = mk(0, 24'h800000, 0, 24'h000001, 8'h96, 1, 0, 0, 0, 1);

        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; OP_A = '0; OP_B = '0;
        repeat (2) @(negedge clk);
        chk_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // isolated beats separated by bubbles
        for (int i = 0; i < NV; i++) begin
            drive(i, 1'b1, 1'b0);
            drive(0, 1'b0, 1'b0);
        end
        repeat (5) drive(0, 1'b0, 1'b0);

        // back-to-back stream, stalls of 2 clocks at beat 3 and beat 6
        for (int b = 0; b < 8; b++) begin
            if (b == 3 || b == 6) begin
                drive(b, 1'b1, 1'b1);
                drive(b, 1'b1, 1'b1);
            end
            drive(b, 1'b1, 1'b0);
        end
        repeat (6) drive(0, 1'b0, 1'b0);

        // async reset with operands in flight
        for (int b = 0; b < 4; b++) begin
            OP_A = va[b]; OP_B = vb[b]; in_valid = 1'b1; stall = 1'b0;
            mon_cur = vexp[b];
            mon_cur.tag = adv_cnt + 4;
            sb_q.push_back(mon_cur);
            if (b < 3) @(negedge clk);
        end
        @(posedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("async_reset");
        sb_q.delete();
        last_ov = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        drive(8, 1'b1, 1'b0);
        chk("post_reset_ov0", 32'(out_valid), 32'd0);
        drive(0, 1'b0, 1'b0);
        chk("post_reset_ov1", 32'(out_valid), 32'd0);
        drive(0, 1'b0, 1'b0);
        chk("post_reset_ov2", 32'(out_valid), 32'd0);
        repeat (6) drive(0, 1'b0, 1'b0);

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
